// File: rtl/matrix_addsub_pipe.sv
// Lane-parallel add/sub/reverse-sub with optional saturation and overflow flags; 2 register stages.
// Latency 2, throughput 1/cycle; in_ready drops combinationally when S1 is full and the output is stalled.
module matrix_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANES  = 8,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   a_in,
    input  logic [LANES*WIDTH-1:0]   b_in,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_ovf,
    output logic                     ovf_sticky,
    input  logic                     clr_sticky
);

    localparam int VW = LANES * WIDTH;

    logic              s1_valid;
    logic [VW-1:0]     s1_a;
    logic [VW-1:0]     s1_b;
    logic [1:0]        s1_mode;
    logic              s1_adv;
    logic              s2_adv;
    logic [VW-1:0]     calc_data;
    logic [LANES-1:0]  calc_ovf;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Returns {ovf, result}. Operands are extended by one bit so the true
    // result of any add/sub of two WIDTH-bit values fits without loss.
    function automatic logic [WIDTH:0] lane_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       m
    );
        logic [WIDTH:0]   ea;
        logic [WIDTH:0]   eb;
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] res;
        logic             ovf;
        ea = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
        eb = (SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b};
        case (m)
            2'b00:   r = ea + eb;
            2'b01:   r = ea - eb;
            default: r = eb - ea;
        endcase
        // Unsigned: bit WIDTH is carry on add and borrow on subtract.
        // Signed: top two bits disagree when the result left the range.
        ovf = (SIGNED != 0) ? (r[WIDTH] ^ r[WIDTH-1]) : r[WIDTH];
        res = r[WIDTH-1:0];
        if (m == 2'b11) begin
            ovf = 1'b0;
            res = a;
        end else if ((SAT != 0) && ovf) begin
            if (SIGNED != 0)
                res = r[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
                res = (m == 2'b00) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
        return {ovf, res};
    endfunction

    always_comb begin
        calc_data = '0;
        calc_ovf  = '0;
        for (int i = 0; i < LANES; i++) begin
            {calc_ovf[LANES-1-i], calc_data[(LANES-i)*WIDTH-1 -: WIDTH]} =
                lane_op(s1_a[(LANES-i)*WIDTH-1 -: WIDTH],
                        s1_b[(LANES-i)*WIDTH-1 -: WIDTH], s1_mode);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_mode    <= 2'b00;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a    <= a_in;
                    s1_b    <= b_in;
                    s1_mode <= mode;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= calc_data;
                    out_ovf  <= calc_ovf;
                end
            end
            // A new overflow event wins over a simultaneous clear.
            if (out_valid && out_ready && (|out_ovf))
                ovf_sticky <= 1'b1;
            else if (clr_sticky)
                ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_addsub_pipe.sv
// Bench for matrix_addsub_pipe: default, signed-saturating and 1-lane 4-bit instances.
module tb_matrix_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         in_valid, in_ready, out_valid, out_ready, ovf_sticky, clr_sticky;
    logic [127:0] a_in, b_in, out_data;
    logic [1:0]   mode;
    logic [7:0]   out_ovf;

    matrix_addsub_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    logic        sa_in_valid, sa_in_ready, sa_out_valid, sa_out_ready, sa_sticky, sa_clr;
    logic [15:0] sa_a, sa_b, sa_out_data;
    logic [1:0]  sa_mode, sa_out_ovf;

    matrix_addsub_pipe #(.WIDTH(8), .LANES(2), .SIGNED(1), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(sa_in_valid), .in_ready(sa_in_ready),
        .a_in(sa_a), .b_in(sa_b), .mode(sa_mode), .out_valid(sa_out_valid),
        .out_ready(sa_out_ready), .out_data(sa_out_data), .out_ovf(sa_out_ovf),
        .ovf_sticky(sa_sticky), .clr_sticky(sa_clr)
    );

    logic       sm_in_valid, sm_in_ready, sm_out_valid, sm_out_ready, sm_sticky, sm_clr;
    logic [3:0] sm_a, sm_b, sm_out_data;
    logic [1:0] sm_mode;
    logic [0:0] sm_out_ovf;

    matrix_addsub_pipe #(.WIDTH(4), .LANES(1), .SIGNED(0), .SAT(0)) u_small (
        .clk(clk), .rst(rst), .in_valid(sm_in_valid), .in_ready(sm_in_ready),
        .a_in(sm_a), .b_in(sm_b), .mode(sm_mode), .out_valid(sm_out_valid),
        .out_ready(sm_out_ready), .out_data(sm_out_data), .out_ovf(sm_out_ovf),
        .ovf_sticky(sm_sticky), .clr_sticky(sm_clr)
    );

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [1:0]   m;
        logic [127:0] d;
        logic [7:0]   o;
    } vec_t;

    typedef struct {
        logic [127:0] d;
        logic [7:0]   o;
    } exp_t;

    vec_t tbl [6];
    exp_t sb [$];
    exp_t cur_exp;
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pop_cnt = 0;
    int   last_pop_cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are sampled mid-cycle; the values are those the next edge acts on.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_output actual=%0h expected=none", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_data", out_data, mon_e.d);
                    chk("sb_ovf", 128'(out_ovf), 128'(mon_e.o));
                    pop_cnt++;
                    last_pop_cyc = cyc;
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic apply(input vec_t v);
        a_in      = v.a;
        b_in      = v.b;
        mode      = v.m;
        cur_exp.d = v.d;
        cur_exp.o = v.o;
    endtask

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        apply(v);
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low expected=in_ready_high");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
        end
    endtask

    task automatic sat_case(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] m, input logic [15:0] d, input logic [1:0] o);
        chk1({name, "_in_ready"}, sa_in_ready, 1'b1);
        sa_a = a; sa_b = b; sa_mode = m; sa_in_valid = 1'b1;
        @(posedge clk); #1;
        sa_in_valid = 1'b0;
        @(posedge clk); #1;
        chk1({name, "_valid"}, sa_out_valid, 1'b1);
        chk({name, "_data"}, 128'(sa_out_data), 128'(d));
        chk({name, "_ovf"}, 128'(sa_out_ovf), 128'(o));
    endtask

    task automatic sm_push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
        sm_a = a; sm_b = b; sm_mode = m; sm_in_valid = 1'b1;
        @(posedge clk); #1;
        sm_in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           it;
        int           n;
        int           first_cyc;
        int           pop_base;
        logic [127:0] held;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        a_in = '0; b_in = '0; mode = 2'b00;
        cur_exp = '{default: '0};
        sa_in_valid = 1'b0; sa_out_ready = 1'b1; sa_clr = 1'b0;
        sa_a = '0; sa_b = '0; sa_mode = 2'b00;
        sm_in_valid = 1'b0; sm_out_ready = 1'b0; sm_clr = 1'b0;
        sm_a = '0; sm_b = '0; sm_mode = 2'b00;
        first_cyc = 0;
        held = '0;

        tbl[0] = '{a: 128'h0005_0003_0000_0000_0000_0000_0000_0000,
                   b: 128'h0003_0005_0000_0000_0000_0000_0000_0000, m: 2'b01,
                   d: 128'h0002_FFFE_0000_0000_0000_0000_0000_0000, o: 8'h40};
        tbl[1] = '{a: 128'hFFFF_1234_0000_0000_0000_0000_0000_8000,
                   b: 128'h0001_1111_0000_0000_0000_0000_0000_8000, m: 2'b00,
                   d: 128'h0000_2345_0000_0000_0000_0000_0000_0000, o: 8'h81};
        tbl[2] = '{a: 128'h0003_0005_0000_0000_0000_0000_0000_0000,
                   b: 128'h0005_0003_0000_0000_0000_0000_0000_0000, m: 2'b10,
                   d: 128'h0002_FFFE_0000_0000_0000_0000_0000_0000, o: 8'h40};
        tbl[3] = '{a: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                   b: {8{16'hFFFF}}, m: 2'b11,
                   d: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, o: 8'h00};
        tbl[4] = '{a: {8{16'hFFFF}}, b: {8{16'h0001}}, m: 2'b01,
                   d: {8{16'hFFFE}}, o: 8'h00};
        tbl[5] = '{a: {8{16'h0001}}, b: {8{16'hFFFF}}, m: 2'b00,
                   d: {8{16'h0000}}, o: 8'hFF};

        repeat (3) @(posedge clk);
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 128'(0));
        chk("reset_out_ovf", 128'(out_ovf), 128'(0));
        chk1("reset_sticky", ovf_sticky, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("post_reset_in_ready", in_ready, 1'b1);

        // Two-cycle latency on an idle pipe.
        apply(tbl[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("lat_cycle1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk1("lat_cycle2_valid", out_valid, 1'b1);
        chk("lat_cycle2_data", out_data, tbl[0].d);
        chk("lat_cycle2_ovf", 128'(out_ovf), 128'(tbl[0].o));
        drain();
        @(posedge clk); #1;
        chk1("sticky_set", ovf_sticky, 1'b1);

        for (int i = 0; i < 6; i++) send(tbl[i]);
        drain();
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        chk1("sticky_clear", ovf_sticky, 1'b0);

        // Ten back-to-back transactions with a 3-cycle output stall.
        it = 0; n = 0; pop_base = pop_cnt;
        in_valid = 1'b1;
        while (n < 10 && it < 100) begin
            out_ready = (it >= 4 && it < 7) ? 1'b0 : 1'b1;
            apply(tbl[n % 6]);
            @(negedge clk);
            if (it == 0) first_cyc = cyc;
            if (it == 4) held = out_data;
            if (it >= 4 && it < 7) begin
                chk1("stall_in_ready", in_ready, 1'b0);
                chk1("stall_out_valid", out_valid, 1'b1);
                chk("stall_data_stable", out_data, held);
            end
            if (in_ready) n++;
            @(posedge clk); #1;
            it++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chki("stream_count", pop_cnt - pop_base, 10);
        chki("stream_span", last_pop_cyc - first_cyc, 14);

        // Reset with two transactions in flight.
        chk1("sticky_pre_reset", ovf_sticky, 1'b1);
        apply(tbl[1]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        apply(tbl[2]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("inflight_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 128'(0));
        chk1("midrst_sticky", ovf_sticky, 1'b0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk1("post_rst_idle", out_valid, 1'b0);
        end
        send(tbl[3]);
        drain();

        sat_case("sat_add", 16'h7010, 16'h2020, 2'b00, 16'h7F30, 2'b10);
        sat_case("sat_rsub", 16'h7F01, 16'h8003, 2'b10, 16'h8002, 2'b10);
        sat_case("sat_sub", 16'h8005, 16'h0107, 2'b01, 16'h80FE, 2'b10);
        sat_case("sat_pass", 16'h8005, 16'h7F7F, 2'b11, 16'h8005, 2'b00);
        @(posedge clk); #1;
        chk1("sat_sticky", sa_sticky, 1'b1);

        chk1("sm_in_ready", sm_in_ready, 1'b1);
        sm_push(4'hF, 4'h1, 2'b00);
        chk1("sm_wrap_valid", sm_out_valid, 1'b1);
        chk("sm_wrap_data", 128'(sm_out_data), 128'(0));
        chk1("sm_wrap_ovf", sm_out_ovf[0], 1'b1);
        chk1("sm_sticky_before_accept", sm_sticky, 1'b0);
        sm_out_ready = 1'b1;
        @(posedge clk); #1;
        sm_out_ready = 1'b0;
        chk1("sm_sticky_after_accept", sm_sticky, 1'b1);
        sm_clr = 1'b1;
        @(posedge clk); #1;
        sm_clr = 1'b0;
        chk1("sm_clear_alone", sm_sticky, 1'b0);
        sm_push(4'hF, 4'h1, 2'b00);
        chk1("sm_second_valid", sm_out_valid, 1'b1);
        sm_out_ready = 1'b1;
        sm_clr = 1'b1;
        @(posedge clk); #1;
        sm_clr = 1'b0;
        chk1("sm_set_and_clear", sm_sticky, 1'b1);
        sm_clr = 1'b1;
        @(posedge clk); #1;
        sm_clr = 1'b0;
        chk1("sm_clear_again", sm_sticky, 1'b0);
        sm_push(4'h9, 4'hF, 2'b11);
        chk1("sm_pass_valid", sm_out_valid, 1'b1);
        chk("sm_pass_data", 128'(sm_out_data), 128'(4'h9));
        chk1("sm_pass_ovf", sm_out_ovf[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
